f_pc_unit: RTL and testbench
============================

# f_pc_unit

Fetch-stage program counter and next-PC unit for the five-stage MIPS pipeline. It consumes the D-stage equality flag `d_cmp_zero` from the D-stage register comparator together with the decoded branch/jump kind, and it holds the registered fetch PC. Branch and jump resolution follows delayed-branch semantics: the delay-slot instruction is already in F when the branch resolves in D. Two wrap-around counters record conditional branch activity for the performance test harness.

## Interface
- `RESET_PC`, 32'h0000_3000, fetch PC value after reset
- `clk`  input  1  system clock, all state updates on rising edge
- `reset`  input  1  synchronous, active-high reset
- `stall`  input  1  from the hazard unit; 1 freezes the PC and the counters
- `d_br_op`  input  3  D-stage control kind: 0 NONE, 1 BEQ, 2 BNE, 3 J (j/jal), 4 JR; codes 5–7 are treated as NONE
- `d_cmp_zero`  input  1  from the D-stage comparator; 1 means rs == rt
- `d_pc`  input  32  PC of the instruction currently in D
- `d_imm16`  input  16  branch offset field
- `d_imm26`  input  26  jump index field
- `d_rs_data`  input  32  forwarded rs value, the JR target
- `f_pc`  output  32  current fetch PC, registered
- `f_npc`  output  32  combinational next PC
- `f_adel`  output  1  sticky misaligned-JR flag; see Configuration
- `br_cnt`  output  32  number of resolved conditional branches
- `taken_cnt`  output  32  number of taken conditional branches

## Operation
- taken = (BEQ & d_cmp_zero) | (BNE & ~d_cmp_zero).
- `f_npc` selection, in priority order:
  - taken branch → `d_pc + 4 + {sext(d_imm16), 2'b00}`, computed mod 2^32.
  - J → `{d_pc[31:28], d_imm26, 2'b00}`, where `d_pc[31:28]` is the region of `d_pc`, the jump's own PC.
  - JR → `d_rs_data`, after the alignment handling described in Configuration.
  - otherwise, including a not-taken BEQ/BNE → `f_pc + 4`.
- Delay slot: while the branch is in D, the delay-slot instruction is being fetched at `f_pc`. The redirect takes effect on the fetch after it. No instruction is flushed.
- Counters:
  - `br_cnt` increments on an edge where `~stall` and `d_br_op` ∈ {BEQ, BNE}.
  - `taken_cnt` increments on such an edge when the branch is also taken.
  - Both wrap from 32'hFFFF_FFFF to 0.

## Timing
- Reset (edge with `reset`=1):
  - `f_pc` = `RESET_PC`.
  - `br_cnt`, `taken_cnt` and `f_adel` are cleared to 0.
  - Reset overrides `stall` and every other input.
  - A branch that is in D when reset is asserted is discarded and not counted.
- Edge with `~reset & ~stall`: `f_pc` ← `f_npc`. One-cycle latency from D-stage resolution to the redirected `f_pc`.
- Edge with `~reset & stall`:
  - `f_pc` and the counters hold.
  - A branch present in D is neither applied nor counted.
  - The hazard unit keeps the branch in D, so it is re-evaluated on the first unstalled edge with the `d_cmp_zero` value of that cycle. The branch is counted exactly once.
- `f_npc` is purely combinational and is valid in every cycle, including while `stall`=1.
- There are no multi-cycle states. All state is the PC register, the two counters and the `f_adel` flag.

## Configuration
- Macro `PC_ALIGN_CHECK_EN`.
- Defined:
  - For JR, if `d_rs_data[1:0]` ≠ 0, the target is `{d_rs_data[31:2], 2'b00}`.
  - `f_adel` sets to 1 on that unstalled edge and stays 1 until reset.
  - A misaligned JR seen while `stall`=1 does not set `f_adel`.
- Undefined:
  - The JR target is `d_rs_data` unmodified.
  - `f_adel` is tied to 0.
  - The port is present in both builds.

## Test plan
- Reset and sequential fetch: hold `reset`=1 for 2 cycles, then release with `d_br_op`=0.
  - Required: `f_pc` = 32'h3000, then 32'h3004, then 32'h3008.
  - Required: both counters stay 0.
- Taken BEQ with negative offset: `d_br_op`=1, `d_cmp_zero`=1, `d_pc`=32'h3010, `d_imm16`=16'hFFFC, `stall`=0.
  - Required: next `f_pc` = 32'h3004.
  - Required: `br_cnt`=1, `taken_cnt`=1.
- Not-taken BNE, then J: BNE with `d_cmp_zero`=1 and `f_pc`=32'h3020.
  - Required: next `f_pc` = 32'h3024, `br_cnt` +1, `taken_cnt` unchanged.
  - Then J with `d_pc`=32'h3020 and `d_imm26`=26'h0000C40. Required: next `f_pc` = 32'h0000_3100.
- Stall over a branch: assert `stall` for 3 cycles with a taken BEQ in D, then deassert.
  - Required: `f_pc` holds for 3 cycles and then takes the target once.
  - Required: `br_cnt` and `taken_cnt` each increment by exactly 1.
- Misaligned JR: `d_br_op`=4, `d_rs_data`=32'h0000_3102.
  - With `PC_ALIGN_CHECK_EN`: `f_pc` = 32'h3100 and `f_adel`=1 until reset.
  - Without it: `f_pc` = 32'h3102 and `f_adel`=0.
- Counter wrap and mid-run reset: preload `taken_cnt` to 32'hFFFF_FFFF by forced state, then apply one taken BEQ.
  - Required: `taken_cnt` = 0.
  - Then assert `reset` with a BEQ in D. Required: all outputs return to their reset values and the BEQ is not counted.

Source files
------------

// File: rtl/f_pc_unit.sv
// f_pc_unit: fetch PC register, next-PC select, branch counters.
// Optional PC_ALIGN_CHECK_EN: word-align JR targets, raise f_adel.
module f_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  d_br_op,
  input  logic        d_cmp_zero,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_rs_data,
  output logic [31:0] f_pc,
  output logic [31:0] f_npc,
  output logic        f_adel,
  output logic [31:0] br_cnt,
  output logic [31:0] taken_cnt
);

  localparam logic [2:0] OP_BEQ = 3'd1;
  localparam logic [2:0] OP_BNE = 3'd2;
  localparam logic [2:0] OP_J   = 3'd3;
  localparam logic [2:0] OP_JR  = 3'd4;

  logic        is_beq;
  logic        is_bne;
  logic        is_j;
  logic        is_jr;
  logic        is_cond;
  logic        taken;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] seq_pc;

  assign is_beq  = (d_br_op == OP_BEQ);
  assign is_bne  = (d_br_op == OP_BNE);
  assign is_j    = (d_br_op == OP_J);
  assign is_jr   = (d_br_op == OP_JR);
  assign is_cond = is_beq | is_bne;
  assign taken   = (is_beq & d_cmp_zero)
                 | (is_bne & ~d_cmp_zero);

  assign br_off = {{14{d_imm16[15]}},
                   d_imm16, 2'b00};
  assign br_tgt = d_pc + 32'd4 + br_off;
  assign j_tgt  = {d_pc[31:28], d_imm26, 2'b00};
  assign seq_pc = f_pc + 32'd4;

`ifdef PC_ALIGN_CHECK_EN
  logic jr_mis;
  assign jr_mis = is_jr & (|d_rs_data[1:0]);
  assign jr_tgt = {d_rs_data[31:2], 2'b00};
`else
  assign jr_tgt = d_rs_data;
`endif

  // next-PC select; the three redirect kinds are mutually exclusive
  always_comb begin
    f_npc = seq_pc;
    unique case (1'b1)
      taken:   f_npc = br_tgt;
      is_j:    f_npc = j_tgt;
      is_jr:   f_npc = jr_tgt;
      default: f_npc = seq_pc;
    endcase
  end

  // fetch PC register, frozen by stall
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc <= RESET_PC;
    end else if (!stall) begin
      f_pc <= f_npc;
    end
  end

  // conditional branch counters, counted once on the unstalled edge
  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (!stall) begin
      if (is_cond) br_cnt <= br_cnt + 32'd1;
      if (taken) taken_cnt <= taken_cnt + 32'd1;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // sticky misaligned-JR flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      f_adel <= 1'b0;
    end else if (!stall && jr_mis) begin
      f_adel <= 1'b1;
    end
  end
`else
  assign f_adel = 1'b0;
`endif

endmodule

// File: tb/tb_f_pc_unit.sv
// tb_f_pc_unit: scoreboard bench for f_pc_unit.
// Build with or without +define+PC_ALIGN_CHECK_EN.
module tb_f_pc_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] br;
    logic [31:0] tk;
    logic        adel;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  d_br_op;
  logic        d_cmp_zero;
  logic [31:0] d_pc;
  logic [15:0] d_imm16;
  logic [25:0] d_imm26;
  logic [31:0] d_rs_data;
  logic [31:0] f_pc;
  logic [31:0] f_npc;
  logic        f_adel;
  logic [31:0] br_cnt;
  logic [31:0] taken_cnt;

  exp_t        sb[$];
  exp_t        e;
  exp_t        got;
  logic [31:0] exp_npc;
  logic [31:0] m_pc;
  logic [31:0] m_br;
  logic [31:0] m_tk;
  logic        m_adel;
  int          n_chk;
  int          n_fail;

  f_pc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .d_br_op    (d_br_op),
    .d_cmp_zero (d_cmp_zero),
    .d_pc       (d_pc),
    .d_imm16    (d_imm16),
    .d_imm26    (d_imm26),
    .d_rs_data  (d_rs_data),
    .f_pc       (f_pc),
    .f_npc      (f_npc),
    .f_adel     (f_adel),
    .br_cnt     (br_cnt),
    .taken_cnt  (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  assign got = '{pc: f_pc, br: br_cnt,
                 tk: taken_cnt, adel: f_adel};

  // drive one cycle of inputs and push the model result
  task automatic drive(
    input logic        rst,
    input logic        st,
    input logic [2:0]  op,
    input logic        cmp,
    input logic [31:0] dpc,
    input logic [15:0] i16,
    input logic [25:0] i26,
    input logic [31:0] rs
  );
    logic        tk;
    logic        cond;
    logic        mis;
    logic [31:0] jr;
    @(negedge clk);
    reset = rst; stall = st; d_br_op = op;
    d_cmp_zero = cmp; d_pc = dpc; d_imm16 = i16;
    d_imm26 = i26; d_rs_data = rs;
    #1;
    cond = (op == 3'd1) || (op == 3'd2);
    tk = (op == 3'd1 && cmp) || (op == 3'd2 && !cmp);
`ifdef PC_ALIGN_CHECK_EN
    jr  = rs & 32'hFFFF_FFFC;
    mis = (op == 3'd4) && (rs[1:0] != 2'b00);
`else
    jr  = rs;
    mis = 1'b0;
`endif
    if (tk)
      exp_npc = dpc + 32'd4 + 32'($signed(i16) * 4);
    else if (op == 3'd3)
      exp_npc = {dpc[31:28], 28'(i26) << 2};
    else if (op == 3'd4)
      exp_npc = jr;
    else
      exp_npc = m_pc + 32'd4;
    if (rst) begin
      m_pc = 32'h0000_3000; m_br = 0;
      m_tk = 0; m_adel = 1'b0;
    end else if (!st) begin
      m_pc = exp_npc;
      m_br = m_br + (cond ? 32'd1 : 32'd0);
      m_tk = m_tk + (tk ? 32'd1 : 32'd0);
      m_adel = m_adel | mis;
    end
    sb.push_back('{pc: m_pc, br: m_br,
                   tk: m_tk, adel: m_adel});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      e = sb.pop_front();
      n_chk++;
      if (got !== e || f_pc !== 32'h3000) begin
        n_fail++;
        $display("FAIL reset: got %h required %h", got, e);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      n_chk++;
      if (f_npc !== exp_npc) begin
        n_fail++;
        $display("FAIL seq_npc: got %h required %h",
                 f_npc, exp_npc);
      end
      tick();
      e = sb.pop_front();
      n_chk++;
      if (got !== e
          || f_pc !== 32'h3004 + 32'(i) * 4
          || br_cnt !== 0 || taken_cnt !== 0) begin
        n_fail++;
        $display("FAIL seq_fetch: got %h required %h",
                 got, e);
      end
    end
  endtask

  task automatic test_beq_taken();
    drive(0, 0, 1, 1, 32'h3010, 16'hFFFC, 0, 0);
    n_chk++;
    if (f_npc !== 32'h3004 || f_npc !== exp_npc) begin
      n_fail++;
      $display("FAIL beq_npc: got %h required %h",
               f_npc, exp_npc);
    end
    tick();
    e = sb.pop_front();
    n_chk++;
    if (got !== e || f_pc !== 32'h3004
        || br_cnt !== 1 || taken_cnt !== 1) begin
      n_fail++;
      $display("FAIL beq_taken: got %h required %h",
               got, e);
    end
  endtask

  task automatic test_bne_j();
    drive(0, 0, 3, 0, 32'h3000, 0, 26'h0000C08, 0);
    tick();
    e = sb.pop_front();
    n_chk++;
    if (got !== e || f_pc !== 32'h3020) begin
      n_fail++;
      $display("FAIL j_setup: got %h required %h",
               got, e);
    end
    drive(0, 0, 2, 1, 32'h3018, 16'h0040, 0, 0);
    n_chk++;
    if (f_npc !== 32'h3024 || f_npc !== exp_npc) begin
      n_fail++;
      $display("FAIL bne_npc: got %h required %h",
               f_npc, exp_npc);
    end
    tick();
    e = sb.pop_front();
    n_chk++;
    if (got !== e || f_pc !== 32'h3024
        || br_cnt !== 2 || taken_cnt !== 1) begin
      n_fail++;
      $display("FAIL bne_nt: got %h required %h",
               got, e);
    end
    drive(0, 0, 3, 0, 32'h3020, 0, 26'h0000C40, 0);
    tick();
    e = sb.pop_front();
    n_chk++;
    if (got !== e || f_pc !== 32'h0000_3100) begin
      n_fail++;
      $display("FAIL jump: got %h required %h",
               got, e);
    end
  endtask

  task automatic test_stall();
    logic [31:0] hold_pc;
    logic [31:0] b0;
    logic [31:0] t0;
    hold_pc = f_pc; b0 = br_cnt; t0 = taken_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, i[0], 32'h3100, 16'h0010, 0, 0);
      n_chk++;
      if (f_npc !== exp_npc) begin
        n_fail++;
        $display("FAIL stall_npc: got %h required %h",
                 f_npc, exp_npc);
      end
      tick();
      e = sb.pop_front();
      n_chk++;
      if (got !== e || f_pc !== hold_pc
          || br_cnt !== b0 || taken_cnt !== t0) begin
        n_fail++;
        $display("FAIL stall_hold: got %h required %h",
                 got, e);
      end
    end
    drive(0, 0, 1, 1, 32'h3100, 16'h0010, 0, 0);
    tick();
    e = sb.pop_front();
    n_chk++;
    if (got !== e || f_pc !== 32'h3144
        || br_cnt !== b0 + 1 || taken_cnt !== t0 + 1) begin
      n_fail++;
      $display("FAIL stall_release: got %h required %h",
               got, e);
    end
  endtask

  task automatic test_jr_misaligned();
    logic [31:0] want_pc;
    logic        want_adel;
`ifdef PC_ALIGN_CHECK_EN
    want_pc = 32'h3100; want_adel = 1'b1;
`else
    want_pc = 32'h3102; want_adel = 1'b0;
`endif
    drive(0, 1, 4, 0, 32'h3140, 0, 0, 32'h0000_3102);
    tick();
    e = sb.pop_front();
    n_chk++;
    if (got !== e || f_adel !== 1'b0) begin
      n_fail++;
      $display("FAIL jr_stalled: got %h required %h",
               got, e);
    end
    drive(0, 0, 4, 0, 32'h3140, 0, 0, 32'h0000_3102);
    tick();
    e = sb.pop_front();
    n_chk++;
    if (got !== e || f_pc !== want_pc
        || f_adel !== want_adel) begin
      n_fail++;
      $display("FAIL jr_mis: got %h required %h",
               got, e);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      e = sb.pop_front();
      n_chk++;
      if (got !== e || f_adel !== want_adel) begin
        n_fail++;
        $display("FAIL adel_sticky: got %h required %h",
                 got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(0, ($urandom_range(3) == 0),
            3'($urandom_range(7)), 1'($urandom),
            {$urandom, 2'b00} >> 2 << 2,
            16'($urandom), 26'($urandom), $urandom);
      n_chk++;
      if (f_npc !== exp_npc) begin
        n_fail++;
        $display("FAIL b2b_npc: got %h required %h",
                 f_npc, exp_npc);
      end
      tick();
      e = sb.pop_front();
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL b2b_state: got %h required %h",
                 got, e);
      end
    end
  endtask

  task automatic test_wrap_reset();
    @(negedge clk);
    force dut.taken_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.taken_cnt;
    m_tk = 32'hFFFF_FFFF;
    drive(0, 0, 1, 1, 32'h3000, 16'h0001, 0, 0);
    tick();
    e = sb.pop_front();
    n_chk++;
    if (got !== e || taken_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL tk_wrap: got %h required %h",
               got, e);
    end
    drive(1, 1, 1, 1, 32'h3000, 16'h0001, 0, 32'h3);
    tick();
    e = sb.pop_front();
    n_chk++;
    if (got !== e || f_pc !== 32'h3000 || br_cnt !== 0
        || taken_cnt !== 0 || f_adel !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h required %h",
               got, e);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    e = sb.pop_front();
    n_chk++;
    if (got !== e || f_pc !== 32'h3004
        || br_cnt !== 0 || taken_cnt !== 0) begin
      n_fail++;
      $display("FAIL post_reset: got %h required %h",
               got, e);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    m_pc = 'x; m_br = 'x; m_tk = 'x; m_adel = 1'bx;
    reset = 1'b1; stall = 1'b0; d_br_op = 3'd0;
    d_cmp_zero = 1'b0; d_pc = '0; d_imm16 = '0;
    d_imm26 = '0; d_rs_data = '0;
    test_reset();
    test_beq_taken();
    test_bne_j();
    test_stall();
    test_jr_misaligned();
    test_back_to_back();
    test_wrap_reset();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d required 0",
               sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
